thread_scheduler: RTL and testbench

Per-cycle thread-issue controller for the barrel RISC-V core; sits in front of the fetch stage and decides which hardware thread fetches each cycle. Tracks per-thread run state (IDLE/READY/SLEEP), round-robins among eligible threads, and enforces a minimum reissue gap so that a thread never has two instructions closer than the pipeline depth, which removes intra-thread hazards without forwarding. Sleep requests come from later stages for multi-cycle events; start and halt come from a control or debug master.

---
 rtl/thread_scheduler_pkg.sv | 13 +
 rtl/thread_scheduler_rr_picker.sv | 32 +++
 rtl/thread_scheduler.sv | 130 +++++++++++++
 tb/tb_thread_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/thread_scheduler_pkg.sv
// rtl/thread_scheduler_pkg.sv - thread-state encoding and scheduler defaults shared with fetch
package thread_scheduler_pkg;

  typedef enum logic [1:0] {
    TS_IDLE  = 2'b00,
    TS_READY = 2'b01,
    TS_SLEEP = 2'b10
  } thread_state_e;

  localparam int DEF_NUM_THREADS = 8;
  localparam int DEF_PIPE_DEPTH  = 5;

endpackage

// File: rtl/thread_scheduler_rr_picker.sv
// rtl/thread_scheduler_rr_picker.sv - combinational round-robin search starting after the pointer
module thread_scheduler_rr_picker #(
  parameter int NUM_THREADS  = 8,
  parameter int BITS_THREADS = 3
) (
  input  logic [NUM_THREADS-1:0]  elig_i,
  input  logic [BITS_THREADS-1:0] ptr_i,
  output logic                    found_o,
  output logic [BITS_THREADS-1:0] tid_o
);

  logic [BITS_THREADS:0]   sum;
  logic [BITS_THREADS-1:0] idx;

  always_comb begin
    found_o = 1'b0;
    tid_o   = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      // one extra bit keeps ptr+k exact before the single wrap subtraction
      sum = {1'b0, ptr_i} + (BITS_THREADS+1)'(k);
      if (sum >= (BITS_THREADS+1)'(NUM_THREADS)) sum = sum - (BITS_THREADS+1)'(NUM_THREADS);
      idx = sum[BITS_THREADS-1:0];
      if (!found_o && elig_i[idx]) begin
        found_o = 1'b1;
        tid_o   = idx;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// rtl/thread_scheduler.sv - per-cycle thread issue: run-state FSMs, reissue gap, round-robin issue slot
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int                     NUM_THREADS  = DEF_NUM_THREADS,
  parameter int                     BITS_THREADS = $clog2(NUM_THREADS),
  parameter int                     PIPE_DEPTH   = DEF_PIPE_DEPTH,
  parameter int                     WAIT_WIDTH   = 8,
  parameter logic [NUM_THREADS-1:0] RESET_MASK   = NUM_THREADS'(1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_THREADS-1:0]  thread_start_i,
  input  logic [NUM_THREADS-1:0]  thread_halt_i,
  input  logic                    stall_req_i,
  input  logic [BITS_THREADS-1:0] stall_tid_i,
  input  logic [WAIT_WIDTH-1:0]   stall_cycles_i,
  input  logic                    issue_ready_i,
  output logic                    issue_valid_o,
  output logic [BITS_THREADS-1:0] issue_tid_o,
  output logic [NUM_THREADS-1:0]  thread_active_o,
  output logic [NUM_THREADS-1:0]  thread_sleep_o,
  output logic                    all_idle_o
);

  localparam int                  GAP_WIDTH = $clog2(PIPE_DEPTH);
  // fire at c loads D-2 at c+1; counter reaches 0 at c+D-1, so the slot refills for c+D
  localparam logic [GAP_WIDTH-1:0] GAP_LOAD = GAP_WIDTH'(PIPE_DEPTH - 2);

  thread_state_e           state_q [NUM_THREADS];
  thread_state_e           state_d [NUM_THREADS];
  logic [WAIT_WIDTH-1:0]   sleep_q [NUM_THREADS];
  logic [WAIT_WIDTH-1:0]   sleep_d [NUM_THREADS];
  logic [GAP_WIDTH-1:0]    gap_q   [NUM_THREADS];
  logic [GAP_WIDTH-1:0]    gap_d   [NUM_THREADS];
  logic [BITS_THREADS-1:0] ptr_q, ptr_d, tid_q, tid_d, ptr_eff, pick_tid;
  logic                    valid_q, valid_d, fire, withdraw, pick_found;
  logic [NUM_THREADS-1:0]  stall_hit, elig;

  assign fire    = valid_q & issue_ready_i;
  assign ptr_eff = fire ? tid_q : ptr_q;

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      stall_hit[t] = stall_req_i && (stall_tid_i == BITS_THREADS'(t)) &&
                     (stall_cycles_i != '0) && (state_q[t] != TS_IDLE);
      state_d[t] = state_q[t];
      sleep_d[t] = sleep_q[t];
      gap_d[t]   = (gap_q[t] != '0) ? gap_q[t] - 1'b1 : '0;
      if (fire && (tid_q == BITS_THREADS'(t))) gap_d[t] = GAP_LOAD;
      if (thread_halt_i[t]) begin
        state_d[t] = TS_IDLE;
        sleep_d[t] = '0;
      end else if (stall_hit[t]) begin
        state_d[t] = TS_SLEEP;
        sleep_d[t] = stall_cycles_i;
      end else if (thread_start_i[t] && (state_q[t] == TS_IDLE)) begin
        state_d[t] = TS_READY;
      end else if (state_q[t] == TS_SLEEP) begin
        if (sleep_q[t] == WAIT_WIDTH'(1)) begin
          state_d[t] = TS_READY;
          sleep_d[t] = '0;
        end else begin
          sleep_d[t] = sleep_q[t] - 1'b1;
        end
      end
      // threads leaving READY this cycle are never loaded into the slot
      elig[t] = (state_q[t] == TS_READY) && (gap_q[t] == '0) &&
                !(valid_q && (tid_q == BITS_THREADS'(t))) &&
                !thread_halt_i[t] && !stall_hit[t];
    end
  end

  thread_scheduler_rr_picker #(
    .NUM_THREADS (NUM_THREADS),
    .BITS_THREADS(BITS_THREADS)
  ) u_rr_picker (
    .elig_i (elig),
    .ptr_i  (ptr_eff),
    .found_o(pick_found),
    .tid_o  (pick_tid)
  );

  always_comb begin
    withdraw = valid_q && !fire && (thread_halt_i[tid_q] || stall_hit[tid_q]);
    ptr_d    = ptr_eff;
    valid_d  = valid_q;
    tid_d    = tid_q;
    if (withdraw) begin
      valid_d = 1'b0;
    end else if (!valid_q || fire) begin
      valid_d = pick_found;
      if (pick_found) tid_d = pick_tid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tid_q   <= '0;
      ptr_q   <= BITS_THREADS'(NUM_THREADS - 1);
      for (int t = 0; t < NUM_THREADS; t++) begin
        state_q[t] <= RESET_MASK[t] ? TS_READY : TS_IDLE;
        sleep_q[t] <= '0;
        gap_q[t]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      tid_q   <= tid_d;
      ptr_q   <= ptr_d;
      for (int t = 0; t < NUM_THREADS; t++) begin
        state_q[t] <= state_d[t];
        sleep_q[t] <= sleep_d[t];
        gap_q[t]   <= gap_d[t];
      end
    end
  end

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      thread_active_o[t] = (state_q[t] != TS_IDLE);
      thread_sleep_o[t]  = (state_q[t] == TS_SLEEP);
    end
  end

  assign all_idle_o    = ~|thread_active_o;
  assign issue_valid_o = valid_q;
  assign issue_tid_o   = tid_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// tb/tb_thread_scheduler.sv - directed scoreboard bench for thread_scheduler
module tb_thread_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] start = '0, halt = '0, stall_cycles = '0;
  logic       stall_req = 1'b0, ready = 1'b1;
  logic [2:0] stall_tid = '0;

  logic       valid, idle, ff_valid, ff_idle;
  logic [2:0] tid, ff_tid;
  logic [7:0] active, sleep, ff_active, ff_sleep;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fire [8];
  bit have_fire [8];
  bit sb_on = 1'b0;
  logic [2:0] sb_q [$];

  thread_scheduler #(.RESET_MASK(8'h01)) u_dut (
    .clk(clk), .rst(rst), .thread_start_i(start), .thread_halt_i(halt),
    .stall_req_i(stall_req), .stall_tid_i(stall_tid), .stall_cycles_i(stall_cycles),
    .issue_ready_i(ready), .issue_valid_o(valid), .issue_tid_o(tid),
    .thread_active_o(active), .thread_sleep_o(sleep), .all_idle_o(idle)
  );

  thread_scheduler #(.RESET_MASK(8'hFF)) u_ff (
    .clk(clk), .rst(rst), .thread_start_i(8'h00), .thread_halt_i(8'h00),
    .stall_req_i(1'b0), .stall_tid_i(3'd0), .stall_cycles_i(8'd0),
    .issue_ready_i(1'b1), .issue_valid_o(ff_valid), .issue_tid_o(ff_tid),
    .thread_active_o(ff_active), .thread_sleep_o(ff_sleep), .all_idle_o(ff_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fire(input logic [2:0] t, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (valid && ready && tid == t) seen = 1'b1;
      tick();
    end
    chk("wait_fire", 32'(seen), 32'd1);
  endtask

  // fire monitor: reissue spacing on every fire, scoreboard order when enabled
  always @(negedge clk) begin
    if (rst) begin
      for (int t = 0; t < 8; t++) have_fire[t] = 1'b0;
    end else if (valid && ready) begin
      if (have_fire[tid]) chk("reissue_gap", 32'((cyc - last_fire[tid]) >= 5), 32'd1);
      last_fire[tid] = cyc;
      have_fire[tid] = 1'b1;
      if (sb_on) begin
        chk("sb_pending", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) chk("sb_tid", 32'(tid), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_tid", 32'(tid), 32'd0);
    chk("rst_active", 32'(active), 32'h01);
    chk("rst_sleep", 32'(sleep), 32'h00);
    chk("rst_idle", 32'(idle), 32'd0);
    chk("rst_ff_active", 32'(ff_active), 32'hFF);
    chk("rst_ff_valid", 32'(ff_valid), 32'd0);
    tick();
    rst = 1'b0;

    // full mask streams 0..7 back to back; single thread fires every 5th cycle
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ff_valid", 32'(ff_valid), 32'd1);
      chk("ff_tid", 32'(ff_tid), 32'(i % 8));
      chk("one_valid", 32'(valid), 32'(i % 5 == 0));
      if (i % 5 == 0) chk("one_tid", 32'(tid), 32'd0);
    end

    // thread 1 started one cycle before thread 0 refires -> 0,1,bubble x3
    wait_fire(3'd0, 10);
    repeat (3) tick();
    start = 8'h02;
    tick();
    start = 8'h00;
    chk("pair_t0", 32'({valid, tid}), 32'({1'b1, 3'd0}));
    tick();
    sb_on = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back(3'd1);
      sb_q.push_back(3'd0);
    end
    for (int j = 0; j < 20; j++) begin
      chk("pair_valid", 32'(valid), 32'((j % 5 == 0) || (j % 5 == 4)));
      tick();
    end
    chk("pair_drain", 32'(sb_q.size()), 32'd0);
    sb_on = 1'b0;

    // all threads; hold tid 2 with ready low
    start = 8'hFF;
    tick();
    start = 8'h00;
    repeat (12) tick();
    wait_fire(3'd1, 16);
    chk("hold_first", 32'({valid, tid}), 32'({1'b1, 3'd2}));
    ready = 1'b0;
    sb_on = 1'b1;
    for (int k = 0; k < 8; k++) sb_q.push_back(3'((k + 2) % 8));
    for (int k = 0; k < 3; k++) begin
      chk("hold_slot", 32'({valid, tid}), 32'({1'b1, 3'd2}));
      tick();
    end
    ready = 1'b1;
    tick();
    chk("after_hold", 32'({valid, tid}), 32'({1'b1, 3'd3}));
    repeat (7) tick();
    chk("hold_drain", 32'(sb_q.size()), 32'd0);
    sb_on = 1'b0;

    // sleep thread 3 for 10 cycles
    stall_req = 1'b1;
    stall_tid = 3'd3;
    stall_cycles = 8'd10;
    tick();
    stall_req = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      chk("sleep3", 32'(sleep[3]), 32'(k <= 10));
      chk("no_tid3", 32'(valid && tid == 3'd3), 32'd0);
      tick();
    end
    wait_fire(3'd3, 20);

    // halt thread 5 while held and stalled
    wait_fire(3'd4, 16);
    chk("held5", 32'({valid, tid}), 32'({1'b1, 3'd5}));
    ready = 1'b0;
    halt = 8'h20;
    tick();
    halt = 8'h00;
    chk("withdraw_valid", 32'(valid), 32'd0);
    chk("halt5_active", 32'(active[5]), 32'd0);
    ready = 1'b1;
    start = 8'h20;
    halt = 8'h20;
    tick();
    start = 8'h00;
    halt = 8'h00;
    chk("start_halt5", 32'(active[5]), 32'd0);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (valid && tid == 3'd5) n++;
      tick();
    end
    chk("no_tid5", 32'(n), 32'd0);
    start = 8'h20;
    tick();
    start = 8'h00;
    chk("restart5", 32'(active[5]), 32'd1);
    wait_fire(3'd5, 20);

    halt = 8'hFF;
    tick();
    halt = 8'h00;
    chk("allhalt_idle", 32'(idle), 32'd1);
    chk("allhalt_active", 32'(active), 32'h00);
    chk("allhalt_valid", 32'(valid), 32'd0);
    tick();
    chk("allhalt_valid2", 32'(valid), 32'd0);

    // mid-stream reset with a sleeping thread
    start = 8'hFF;
    tick();
    start = 8'h00;
    repeat (6) tick();
    stall_req = 1'b1;
    stall_tid = 3'd2;
    stall_cycles = 8'd100;
    tick();
    stall_req = 1'b0;
    chk("pre_rst_sleep", 32'(sleep), 32'h04);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_sleep", 32'(sleep), 32'h00);
    chk("mid_rst_active", 32'(active), 32'h01);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_on = 1'b1;
    for (int k = 0; k < 3; k++) sb_q.push_back(3'd0);
    for (int j = 0; j < 15; j++) begin
      tick();
      chk("post_rst_valid", 32'(valid), 32'(j % 5 == 0));
    end
    tick();
    chk("post_rst_drain", 32'(sb_q.size()), 32'd0);
    sb_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
